rx_fcs_chk16: RTL and testbench

Receive-side Ethernet FCS checker for the 16-bit MAC datapath, the counterpart of the transmit-side CRC-32 generator. It consumes a framed 16-bit beat stream (SOP/EOP/odd-byte marker) and accumulates CRC-32 over every byte including the trailing 4-byte FCS. At end of frame it compares the register against the fixed good-frame residue and emits a one-cycle status pulse with CRC, length and abort results. It sits between the RX PCS/alignment stage and the RX FIFO write logic, which uses the status to commit or drop the frame.

---
 rtl/rx_fcs_chk16_pkg.sv | 27 ++
 rtl/crc32_d16s.sv | 12 +
 rtl/crc32_d8s.sv | 12 +
 rtl/rx_fcs_chk16.sv | 182 ++++++++++++++++++
 tb/tb_rx_fcs_chk16.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_fcs_chk16_pkg.sv
// Shared MAC definitions for the receive FCS checker: CRC-32 constants, Ethernet
// length limits, FSM state type and the bit-serial CRC-32 byte step.
package rx_fcs_chk16_pkg;

  localparam logic [31:0] CRC32_INIT            = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE_DEFAULT = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY            = 32'h04C11DB7;
  localparam int          ETH_MIN_LEN           = 64;
  localparam int          ETH_MAX_LEN           = 1518;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } fsm_state_e;

  // Register is kept MSB-first while each byte enters LSB-first, as on the wire.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d16s.sv
// Combinational CRC-32 step over one 16-bit beat; data_i[15:8] is the earlier byte.
module crc32_d16s
  import rx_fcs_chk16_pkg::*;
(
  input  logic [31:0] seed_i,
  input  logic [15:0] data_i,
  output logic [31:0] crc_o
);

  assign crc_o = crc32_byte(crc32_byte(seed_i, data_i[15:8]), data_i[7:0]);

endmodule

// File: rtl/crc32_d8s.sv
// Combinational CRC-32 step over one byte with an explicit 32-bit seed.
module crc32_d8s
  import rx_fcs_chk16_pkg::*;
(
  input  logic [31:0] seed_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  assign crc_o = crc32_byte(seed_i, data_i);

endmodule

// File: rtl/rx_fcs_chk16.sv
// Receive-side Ethernet FCS checker for the 16-bit datapath with registered frame status.
// Optional statistics counters are built when RX_FCS_STATS_EN is defined.
module rx_fcs_chk16
  import rx_fcs_chk16_pkg::*;
#(
  parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE_DEFAULT,
  parameter int          MIN_LEN     = ETH_MIN_LEN,
  parameter int          MAX_LEN     = ETH_MAX_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_vld,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic        rx_mod,
  input  logic [15:0] rx_data,
  output logic        chk_vld,
  output logic        chk_ok,
  output logic        chk_crc_err,
  output logic        chk_len_err,
  output logic        chk_abort,
  output logic [15:0] chk_len,
  input  logic        stat_clr,
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad
);

  localparam logic [15:0] MinLen = 16'(MIN_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  fsm_state_e  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        pend_q, pend_d;

  logic        odd_tail;
  logic [31:0] seed, crc16_out, crc8_out, crc_next;
  logic [15:0] len_base, len_next;
  logic [1:0]  len_inc;
  logic [16:0] len_sum;
  logic        new_crc_err, new_len_err, old_crc_err, old_len_err;

  logic        rep_vld, rep_abort, rep_crc_err, rep_len_err, rep_ok;
  logic [15:0] rep_len;

  logic        chk_vld_q, chk_ok_q, chk_crc_err_q, chk_len_err_q, chk_abort_q;
  logic [15:0] chk_len_q;

  assign odd_tail = rx_eop & rx_mod;
  assign seed     = rx_sop ? CRC32_INIT : crc_q;

  crc32_d16s u_crc16 (.seed_i(seed), .data_i(rx_data),       .crc_o(crc16_out));
  crc32_d8s  u_crc8  (.seed_i(seed), .data_i(rx_data[15:8]), .crc_o(crc8_out));

  assign crc_next = odd_tail ? crc8_out : crc16_out;
  assign len_base = rx_sop ? 16'd0 : len_q;
  assign len_inc  = odd_tail ? 2'd1 : 2'd2;
  assign len_sum  = {1'b0, len_base} + {15'd0, len_inc};
  assign len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  assign new_crc_err = (crc_next != CRC_RESIDUE);
  assign new_len_err = (len_next < MinLen) | (len_next > MaxLen);
  assign old_crc_err = (crc_q != CRC_RESIDUE);
  assign old_len_err = (len_q < MinLen) | (len_q > MaxLen);

  // A deferred single-beat frame (pend_q) is reported from crc_q/len_q; if another
  // single-beat frame lands in that same cycle it takes over the deferred slot.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    pend_d      = 1'b0;
    rep_vld     = pend_q;
    rep_abort   = 1'b0;
    rep_crc_err = old_crc_err;
    rep_len_err = old_len_err;
    rep_len     = len_q;
    case (state_q)
      IDLE: begin
        if (rx_vld && rx_sop) begin
          crc_d = crc_next;
          len_d = len_next;
          if (!rx_eop) begin
            state_d = FRAME;
          end else if (pend_q) begin
            pend_d = 1'b1;
          end else begin
            rep_vld     = 1'b1;
            rep_crc_err = new_crc_err;
            rep_len_err = new_len_err;
            rep_len     = len_next;
          end
        end
      end
      FRAME: begin
        if (rx_vld) begin
          crc_d = crc_next;
          len_d = len_next;
          if (rx_sop) begin
            rep_vld     = 1'b1;
            rep_abort   = 1'b1;
            rep_crc_err = 1'b0;
            rep_len_err = old_len_err;
            rep_len     = len_q;
            if (rx_eop) begin
              pend_d  = 1'b1;
              state_d = IDLE;
            end
          end else if (rx_eop) begin
            rep_vld     = 1'b1;
            rep_crc_err = new_crc_err;
            rep_len_err = new_len_err;
            rep_len     = len_next;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rep_ok = !(rep_abort | rep_crc_err | rep_len_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      crc_q         <= CRC32_INIT;
      len_q         <= '0;
      pend_q        <= 1'b0;
      chk_vld_q     <= 1'b0;
      chk_ok_q      <= 1'b0;
      chk_crc_err_q <= 1'b0;
      chk_len_err_q <= 1'b0;
      chk_abort_q   <= 1'b0;
      chk_len_q     <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      pend_q    <= pend_d;
      chk_vld_q <= rep_vld;
      if (rep_vld) begin
        chk_ok_q      <= rep_ok;
        chk_crc_err_q <= rep_crc_err;
        chk_len_err_q <= rep_len_err;
        chk_abort_q   <= rep_abort;
        chk_len_q     <= rep_len;
      end
    end
  end

  assign chk_vld     = chk_vld_q;
  assign chk_ok      = chk_ok_q;
  assign chk_crc_err = chk_crc_err_q;
  assign chk_len_err = chk_len_err_q;
  assign chk_abort   = chk_abort_q;
  assign chk_len     = chk_len_q;

`ifdef RX_FCS_STATS_EN
  logic [31:0] stat_good_q, stat_bad_q;

  // Counters step on the same edge that raises chk_vld; a clear wins over a count.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_good_q <= '0;
      stat_bad_q  <= '0;
    end else if (rep_vld) begin
      if (rep_ok && (stat_good_q != 32'hFFFFFFFF)) stat_good_q <= stat_good_q + 32'd1;
      if (!rep_ok && (stat_bad_q != 32'hFFFFFFFF)) stat_bad_q <= stat_bad_q + 32'd1;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_bad  = stat_bad_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_good       = '0;
  assign stat_bad        = '0;
`endif

endmodule

// File: tb/tb_rx_fcs_chk16.sv
// Self-checking bench for rx_fcs_chk16: frames are built as byte queues with a
// reflected CRC-32 reference and every status strobe is scored against them.
module tb_rx_fcs_chk16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rxVld, rxSop, rxEop, rxMod, statClr;
   logic [15:0] rxData;
   logic        chkVld, chkOk, chkCrcErr, chkLenErr, chkAbort;
   logic [15:0] chkLen;
   logic [31:0] statGood, statBad;

   typedef struct {
      bit     abort;
      bit     crcErr;
      bit     lenErr;
      int     len;
      longint cyc;
      bit     clr;
   } expT;

   expT          expQ[$];
   byte unsigned txBytes[$];
   int           checkCount = 0;
   int           failCount = 0;
   longint       cycCnt = 0;
   int           modelGood = 0;
   int           modelBad = 0;
   bit           abortPending = 0;
   int           abortLen = 0;
   logic [19:0]  lastStatus = '0;
   expT          monExp;
   bit           monOk;

   rx_fcs_chk16 dut (
      .clk(clk), .rst(rst),
      .rx_vld(rxVld), .rx_sop(rxSop), .rx_eop(rxEop), .rx_mod(rxMod), .rx_data(rxData),
      .chk_vld(chkVld), .chk_ok(chkOk), .chk_crc_err(chkCrcErr), .chk_len_err(chkLenErr),
      .chk_abort(chkAbort), .chk_len(chkLen),
      .stat_clr(statClr), .stat_good(statGood), .stat_bad(statBad)
   );

   // Free-running clock and a cycle counter used to predict strobe timing
   always #5 clk = ~clk;
   always @(posedge clk) cycCnt++;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Standard reflected CRC-32 over the first n bytes of txBytes, no final inversion
   function automatic logic [31:0] refCrc(input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'd0, txBytes[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   // Random payload followed by its FCS (complemented CRC, low byte first)
   function automatic void buildFrame(input int totalLen, input bit good);
      logic [31:0]  f;
      byte unsigned mask;
      txBytes.delete();
      for (int i = 0; i < totalLen - 4; i++) txBytes.push_back(8'($urandom));
      f = ~refCrc(totalLen - 4);
      for (int k = 0; k < 4; k++) txBytes.push_back(f[8*k +: 8]);
      if (!good) begin
         mask = 8'(1 << $urandom_range(0, 7));
         txBytes[$urandom_range(0, totalLen - 1)] ^= mask;
      end
   endfunction

   // Expected report for the whole frame in txBytes: a good frame leaves 0xDEBB20E3
   function automatic expT frameExp(input longint cyc, input bit clr);
      expT e;
      int  n;
      n        = txBytes.size();
      e.abort  = 1'b0;
      e.len    = n;
      e.crcErr = (refCrc(n) != 32'hDEBB20E3);
      e.lenErr = (n < 64) || (n > 1518);
      e.cyc    = cyc;
      e.clr    = clr;
      return e;
   endfunction

   // Sends txBytes as beats; cutBeats > 0 sends only that many beats and leaves the frame open
   task automatic applyStimulus(input int cutBeats, input bit clrAtEop);
      int  n;
      int  beats;
      bit  last;
      bit  aborted;
      expT e;
      n       = txBytes.size();
      beats   = (cutBeats > 0) ? cutBeats : (n + 1) / 2;
      aborted = 1'b0;
      for (int k = 0; k < beats; k++) begin
         last = (cutBeats == 0) && (k == beats - 1);
         @(posedge clk); #1;
         rxVld          = 1'b1;
         rxSop          = (k == 0);
         rxEop          = last;
         rxMod          = last ? n[0] : 1'($urandom_range(0, 1));
         rxData[15:8]   = txBytes[2*k];
         rxData[7:0]    = (2*k + 1 < n) ? txBytes[2*k + 1] : 8'($urandom);
         statClr        = last && clrAtEop;
         if (k == 0 && abortPending) begin
            e.abort  = 1'b1;
            e.crcErr = 1'b0;
            e.len    = abortLen;
            e.lenErr = (abortLen < 64) || (abortLen > 1518);
            e.cyc    = cycCnt + 1;
            e.clr    = 1'b0;
            expQ.push_back(e);
            abortPending = 1'b0;
            aborted      = 1'b1;
         end
         if (last) expQ.push_back(frameExp(cycCnt + ((aborted && k == 0) ? 2 : 1), clrAtEop));
      end
      if (cutBeats > 0) begin
         abortPending = 1'b1;
         abortLen     = 2 * cutBeats;
      end
   endtask

   task automatic idleCycles(input int cnt);
      repeat (cnt) begin
         @(posedge clk); #1;
         rxVld   = 1'b0;
         rxSop   = 1'($urandom);
         rxEop   = 1'($urandom);
         rxMod   = 1'($urandom);
         rxData  = 16'($urandom);
         statClr = 1'b0;
      end
   endtask

   // Valid beat without SOP outside a frame; must be ignored
   task automatic strayBeat();
      @(posedge clk); #1;
      rxVld   = 1'b1;
      rxSop   = 1'b0;
      rxEop   = 1'($urandom);
      rxMod   = 1'($urandom);
      rxData  = 16'($urandom);
      statClr = 1'b0;
   endtask

   task automatic waitDrain();
      int t;
      t = 0;
      while (expQ.size() > 0 && t < 20) begin
         idleCycles(1);
         t++;
      end
      checkOutput("drain", expQ.size(), 0);
   endtask

   task automatic clearStats();
      @(posedge clk); #1;
      rxVld     = 1'b0;
      statClr   = 1'b1;
      modelGood = 0;
      modelBad  = 0;
      idleCycles(1);
   endtask

   // Scoreboard: pops one expected report per strobe and checks status hold between strobes
   always @(negedge clk) begin
      if (rst) begin
         lastStatus = '0;
      end else if (chkVld) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_strobe", 1, 0);
         end else begin
            monExp = expQ.pop_front();
            monOk  = !(monExp.abort || monExp.crcErr || monExp.lenErr);
            checkOutput("strobe_cycle", cycCnt, monExp.cyc);
            checkOutput("chk_abort", chkAbort, monExp.abort);
            checkOutput("chk_crc_err", chkCrcErr, monExp.crcErr);
            checkOutput("chk_len_err", chkLenErr, monExp.lenErr);
            checkOutput("chk_ok", chkOk, monOk);
            checkOutput("chk_len", chkLen, monExp.len);
            if (monExp.clr) begin
               modelGood = 0;
               modelBad  = 0;
            end else if (monOk) begin
               modelGood++;
            end else begin
               modelBad++;
            end
`ifdef RX_FCS_STATS_EN
            checkOutput("stat_good", statGood, modelGood);
            checkOutput("stat_bad", statBad, modelBad);
`else
            checkOutput("stat_good_tied", statGood, 0);
            checkOutput("stat_bad_tied", statBad, 0);
`endif
         end
         lastStatus = {chkOk, chkCrcErr, chkLenErr, chkAbort, chkLen};
      end else begin
         checkOutput("status_hold", {chkOk, chkCrcErr, chkLenErr, chkAbort, chkLen}, lastStatus);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then boundaries, randomized traffic and statistics
   initial begin
      int lens[4];
      int len;
      int cut;
      bit good;
      rst     = 1'b1;
      rxVld   = 1'b0;
      rxSop   = 1'b0;
      rxEop   = 1'b0;
      rxMod   = 1'b0;
      rxData  = '0;
      statClr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_chk_vld", chkVld, 0);
      checkOutput("reset_chk_ok", chkOk, 0);
      checkOutput("reset_chk_crc_err", chkCrcErr, 0);
      checkOutput("reset_chk_len_err", chkLenErr, 0);
      checkOutput("reset_chk_abort", chkAbort, 0);
      checkOutput("reset_chk_len", chkLen, 0);
      checkOutput("reset_stat_good", statGood, 0);
      checkOutput("reset_stat_bad", statBad, 0);

      $display("[TB] good 64-byte frame, then same frame with beat 10 bit 3 flipped");
      buildFrame(64, 1'b1);
      applyStimulus(0, 1'b0);
      waitDrain();
      txBytes[21] ^= 8'h08;
      applyStimulus(0, 1'b0);
      waitDrain();

      $display("[TB] good 65-byte frame and single-beat 0x1234 frame");
      buildFrame(65, 1'b1);
      applyStimulus(0, 1'b0);
      waitDrain();
      txBytes = '{8'h12, 8'h34};
      applyStimulus(0, 1'b0);
      waitDrain();

      $display("[TB] abort at beat 20 followed by good frame; abort followed by single beat");
      buildFrame(80, 1'b1);
      applyStimulus(19, 1'b0);
      buildFrame(64, 1'b1);
      applyStimulus(0, 1'b0);
      waitDrain();
      buildFrame(50, 1'b1);
      applyStimulus(10, 1'b0);
      txBytes = '{8'hAB};
      applyStimulus(0, 1'b0);
      waitDrain();

      $display("[TB] reset in the middle of a frame");
      buildFrame(64, 1'b1);
      applyStimulus(12, 1'b0);
      abortPending = 1'b0;
      @(posedge clk); #1;
      rst   = 1'b1;
      rxVld = 1'b0;
      @(posedge clk); #1;
      rst       = 1'b0;
      modelGood = 0;
      modelBad  = 0;
      idleCycles(3);
      checkOutput("post_rst_chk_len", chkLen, 0);
      buildFrame(64, 1'b1);
      applyStimulus(0, 1'b0);
      waitDrain();

      $display("[TB] length boundaries back to back");
      lens = '{63, 64, 1518, 1519};
      foreach (lens[i]) begin
         buildFrame(lens[i], 1'b1);
         applyStimulus(0, 1'b0);
      end
      waitDrain();

      $display("[TB] randomized traffic");
      for (int f = 0; f < 30; f++) begin
         len  = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 63) : $urandom_range(60, 140);
         good = ($urandom_range(0, 3) != 0);
         buildFrame(len, good);
         cut = 0;
         if (f != 29 && $urandom_range(0, 4) == 0) cut = $urandom_range(1, (len + 1) / 2 - 1);
         applyStimulus(cut, 1'b0);
         if (cut == 0) begin
            idleCycles($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) strayBeat();
         end
      end
      waitDrain();

      $display("[TB] statistics: 3 good, 2 bad, then clear coinciding with a strobe");
      clearStats();
      for (int f = 0; f < 5; f++) begin
         buildFrame(64 + f, (f % 2) == 0);
         applyStimulus(0, 1'b0);
      end
      waitDrain();
`ifdef RX_FCS_STATS_EN
      checkOutput("stat_good_3", statGood, 3);
      checkOutput("stat_bad_2", statBad, 2);
`else
      checkOutput("stat_good_off", statGood, 0);
      checkOutput("stat_bad_off", statBad, 0);
`endif
      buildFrame(64, 1'b1);
      applyStimulus(0, 1'b1);
      waitDrain();
      checkOutput("stat_good_clr", statGood, 0);
      checkOutput("stat_bad_clr", statBad, 0);

      idleCycles(3);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
